// File: rtl/btn_event_dec_pkg.sv
// Shared definitions for the button gesture decoder: FSM state encodings and
// default tick constants.
package btn_event_dec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS1   = 3'd1,
        ST_WAIT_DBL = 3'd2,
        ST_PRESS2   = 3'd3,
        ST_LONG     = 3'd4
    } btn_state_e;

    localparam int DEF_CNT_W      = 12;
    localparam int DEF_LONG_TICKS = 1000;
    localparam int DEF_DBL_TICKS  = 250;
    localparam int DEF_RPT_TICKS  = 100;

endpackage

// File: rtl/btn_tick_timer.sv
// Tick counter with synchronous clear, CE-gated increment and a runtime limit.
// tc fires on the CE that reaches limit_m1; the counter then restarts at zero.
module btn_tick_timer #(
    parameter int CNT_W = 12
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             ce,
    input  logic [CNT_W-1:0] limit_m1,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_r;

    assign tc = ce && (cnt_r == limit_m1);

    // Counter: clear has priority, wrap on terminal count so it never passes the limit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr || tc) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (ce) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/btn_event_dec.sv
// Button gesture decoder: classifies a debounced button level into short,
// double and long presses, with auto-repeat pulses while held long.
module btn_event_dec
    import btn_event_dec_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LONG_TICKS = DEF_LONG_TICKS,
    parameter int DBL_TICKS  = DEF_DBL_TICKS,
    parameter int RPT_TICKS  = DEF_RPT_TICKS
) (
    input  logic CLK,
    input  logic RST,
    input  logic CE,
    input  logic BTN,
    output logic SHORT_P,
    output logic DOUBLE_P,
    output logic LONG_P,
    output logic REPEAT_P,
    output logic HELD
);

    localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DBL_M1  = CNT_W'(DBL_TICKS - 1);
    localparam logic [CNT_W-1:0] RPT_M1  = CNT_W'(RPT_TICKS - 1);

    btn_state_e       state_r;
    btn_state_e       state_nx_s;
    logic             clr_s;
    logic             tc_s;
    logic [CNT_W-1:0] limit_s;
    logic             short_nx_s;
    logic             double_nx_s;
    logic             long_nx_s;
    logic             repeat_nx_s;
    logic             short_r;
    logic             double_r;
    logic             long_r;
    logic             repeat_r;
    logic             held_r;

    btn_tick_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (clr_s),
        .ce       (CE),
        .limit_m1 (limit_s),
        .tc       (tc_s)
    );

    // Next-state and pulse decode; a BTN change always wins over a same-cycle timeout
    always_comb begin
        state_nx_s  = state_r;
        clr_s       = 1'b0;
        limit_s     = {CNT_W{1'b0}};
        short_nx_s  = 1'b0;
        double_nx_s = 1'b0;
        long_nx_s   = 1'b0;
        repeat_nx_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clr_s = 1'b1;
                if (BTN) begin
                    state_nx_s = ST_PRESS1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PRESS1: begin
                limit_s = LONG_M1;
                if (!BTN) begin
                    state_nx_s = ST_WAIT_DBL;
                    clr_s      = 1'b1;
                end else if (tc_s) begin
                    state_nx_s = ST_LONG;
                    clr_s      = 1'b1;
                    long_nx_s  = 1'b1;
                end else begin
                    state_nx_s = ST_PRESS1;
                end
            end
            ST_WAIT_DBL: begin
                limit_s = DBL_M1;
                if (BTN) begin
                    state_nx_s = ST_PRESS2;
                    clr_s      = 1'b1;
                end else if (tc_s) begin
                    state_nx_s = ST_IDLE;
                    clr_s      = 1'b1;
                    short_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_WAIT_DBL;
                end
            end
            ST_PRESS2: begin
                limit_s = LONG_M1;
                if (!BTN) begin
                    state_nx_s  = ST_IDLE;
                    clr_s       = 1'b1;
                    double_nx_s = 1'b1;
                end else if (tc_s) begin
                    state_nx_s = ST_LONG;
                    clr_s      = 1'b1;
                    long_nx_s  = 1'b1;
                end else begin
                    state_nx_s = ST_PRESS2;
                end
            end
            ST_LONG: begin
                limit_s = RPT_M1;
                if (!BTN) begin
                    state_nx_s = ST_IDLE;
                    clr_s      = 1'b1;
                end else if (tc_s) begin
                    state_nx_s  = ST_LONG;
                    repeat_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_LONG;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                clr_s      = 1'b1;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r  <= ST_IDLE;
            short_r  <= 1'b0;
            double_r <= 1'b0;
            long_r   <= 1'b0;
            repeat_r <= 1'b0;
            held_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            short_r  <= short_nx_s;
            double_r <= double_nx_s;
            long_r   <= long_nx_s;
            repeat_r <= repeat_nx_s;
            held_r   <= (state_nx_s == ST_LONG);
        end
    end

    assign SHORT_P  = short_r;
    assign DOUBLE_P = double_r;
    assign LONG_P   = long_r;
    assign REPEAT_P = repeat_r;
    assign HELD     = held_r;

endmodule

// File: tb/tb_btn_event_dec.sv
// Self-checking bench for btn_event_dec: gesture-level model compared every cycle,
// plus directed scenarios with hand-computed pulse counts and timing.
module tb_btn_event_dec;

    localparam int LT = 8;
    localparam int DT = 4;
    localparam int RT = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic CE  = 1'b0;
    logic BTN = 1'b0;
    logic SHORT_P, DOUBLE_P, LONG_P, REPEAT_P, HELD;

    int n_tests = 0;
    int n_fail  = 0;
    int c_short = 0, c_double = 0, c_long = 0, c_rep = 0;
    int b_short = 0, b_double = 0, b_long = 0, b_rep = 0;

    // gesture model state
    int   m_presses = 0;
    bit   m_down    = 1'b0;
    bit   m_long    = 1'b0;
    int   m_ticks   = 0;
    logic m_short = 1'b0, m_double = 1'b0, m_lp = 1'b0, m_rep = 1'b0, m_held = 1'b0;

    btn_event_dec #(
        .CNT_W      (4),
        .LONG_TICKS (LT),
        .DBL_TICKS  (DT),
        .RPT_TICKS  (RT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CE       (CE),
        .BTN      (BTN),
        .SHORT_P  (SHORT_P),
        .DOUBLE_P (DOUBLE_P),
        .LONG_P   (LONG_P),
        .REPEAT_P (REPEAT_P),
        .HELD     (HELD)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Gesture model: number of presses so far, whether the button is down,
    // whether the hold became long, and ticks elapsed since the last milestone.
    always @(posedge CLK or posedge RST) begin : model
        int p, t;
        bit dn, lg;
        logic s, d, l, r;
        if (RST) begin
            m_presses <= 0; m_down <= 1'b0; m_long <= 1'b0; m_ticks <= 0;
            m_short <= 1'b0; m_double <= 1'b0; m_lp <= 1'b0; m_rep <= 1'b0; m_held <= 1'b0;
        end else begin
            p = m_presses; dn = m_down; lg = m_long; t = m_ticks;
            s = 1'b0; d = 1'b0; l = 1'b0; r = 1'b0;
            if (lg) begin
                if (!BTN) begin lg = 1'b0; p = 0; dn = 1'b0; t = 0; end
                else if (CE) begin t++; if (t == RT) begin r = 1'b1; t = 0; end end
            end else if (p == 0) begin
                if (BTN) begin p = 1; dn = 1'b1; t = 0; end
            end else if (dn) begin
                if (!BTN) begin
                    if (p == 1) begin dn = 1'b0; t = 0; end
                    else begin d = 1'b1; p = 0; dn = 1'b0; t = 0; end
                end else if (CE) begin
                    t++;
                    if (t == LT) begin l = 1'b1; lg = 1'b1; p = 0; dn = 1'b0; t = 0; end
                end
            end else begin
                if (BTN) begin p = 2; dn = 1'b1; t = 0; end
                else if (CE) begin t++; if (t == DT) begin s = 1'b1; p = 0; t = 0; end end
            end
            m_presses <= p; m_down <= dn; m_long <= lg; m_ticks <= t;
            m_short <= s; m_double <= d; m_lp <= l; m_rep <= r; m_held <= lg;
        end
    end

    // Every-cycle comparison against the model plus pulse tallies
    always @(negedge CLK) begin
        chk("short_p",  SHORT_P,  m_short);
        chk("double_p", DOUBLE_P, m_double);
        chk("long_p",   LONG_P,   m_lp);
        chk("repeat_p", REPEAT_P, m_rep);
        chk("held",     HELD,     m_held);
        chk("one_pulse", ($countones({SHORT_P, DOUBLE_P, LONG_P, REPEAT_P}) <= 1), 1'b1);
        c_short  += int'(SHORT_P === 1'b1);
        c_double += int'(DOUBLE_P === 1'b1);
        c_long   += int'(LONG_P === 1'b1);
        c_rep    += int'(REPEAT_P === 1'b1);
    end

    // One tick: BTN changes on a non-CE cycle, CE strobes on the next cycle
    task automatic tick(input logic b);
        @(negedge CLK);
        BTN = b;
        CE  = 1'b0;
        @(negedge CLK);
        CE  = 1'b1;
    endtask

    task automatic ticks(input logic b, input int n);
        for (int i = 0; i < n; i++) tick(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            CE = 1'b0;
        end
    endtask

    task automatic mark();
        #1;
        b_short = c_short; b_double = c_double; b_long = c_long; b_rep = c_rep;
    endtask

    task automatic expect_counts(input string name, input int s, input int d, input int l, input int r);
        #1;
        chk_int({name, "_short"},  c_short  - b_short,  s);
        chk_int({name, "_double"}, c_double - b_double, d);
        chk_int({name, "_long"},   c_long   - b_long,   l);
        chk_int({name, "_repeat"}, c_rep    - b_rep,    r);
    endtask

    initial begin
        RST = 1'b1; BTN = 1'b0; CE = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_short", SHORT_P, 1'b0);
        chk("rst_held",  HELD,    1'b0);
        chk("rst_long",  LONG_P,  1'b0);
        @(negedge CLK);
        RST = 1'b0;
        idle(2);

        // short press: 3 ticks high, SHORT_P right after the 4th tick low
        mark();
        ticks(1'b1, 3);
        ticks(1'b0, 4);
        @(negedge CLK); CE = 1'b0;
        chk("s1_short_at_tick4", SHORT_P, 1'b1);
        ticks(1'b0, 3); idle(2);
        expect_counts("s1", 1, 0, 0, 0);

        // double press
        mark();
        ticks(1'b1, 2); ticks(1'b0, 1); ticks(1'b1, 2);
        @(negedge CLK); BTN = 1'b0; CE = 1'b0;
        @(negedge CLK);
        chk("s2_double_at_release", DOUBLE_P, 1'b1);
        ticks(1'b0, 6); idle(2);
        expect_counts("s2", 0, 1, 0, 0);

        // long press with auto-repeat
        mark();
        ticks(1'b1, 8);
        @(negedge CLK); CE = 1'b0;
        chk("s3_long_at_tick8", LONG_P, 1'b1);
        chk("s3_held", HELD, 1'b1);
        ticks(1'b1, 3);
        @(negedge CLK); CE = 1'b0;
        chk("s3_repeat_tick11", REPEAT_P, 1'b1);
        ticks(1'b1, 3);
        @(negedge CLK); CE = 1'b0;
        chk("s3_repeat_tick14", REPEAT_P, 1'b1);
        ticks(1'b1, 1);
        @(negedge CLK); BTN = 1'b0; CE = 1'b0;
        @(negedge CLK);
        chk("s3_held_released", HELD, 1'b0);
        idle(10);
        expect_counts("s3", 0, 0, 1, 2);

        // release coincident with the timeout tick: release wins
        mark();
        ticks(1'b1, 7);
        @(negedge CLK); BTN = 1'b0; CE = 1'b1;
        @(negedge CLK); CE = 1'b0;
        chk("s4_no_long", LONG_P, 1'b0);
        ticks(1'b0, 4);
        @(negedge CLK); CE = 1'b0;
        chk("s4_short_late", SHORT_P, 1'b1);
        idle(4);
        expect_counts("s4", 1, 0, 0, 0);

        // second press held long: LONG_P only
        mark();
        ticks(1'b1, 1); ticks(1'b0, 1); ticks(1'b1, 8);
        @(negedge CLK); CE = 1'b0;
        chk("s5_long", LONG_P, 1'b1);
        @(negedge CLK); BTN = 1'b0;
        idle(10);
        expect_counts("s5", 0, 0, 1, 0);

        // triple press: third press starts a fresh gesture ending in SHORT_P
        mark();
        ticks(1'b1, 1); ticks(1'b0, 1); ticks(1'b1, 1);
        ticks(1'b0, 1); ticks(1'b1, 1); ticks(1'b0, 5); idle(2);
        expect_counts("s6", 1, 1, 0, 0);

        // CE tied low: timeouts freeze, no pulses
        mark();
        @(negedge CLK); BTN = 1'b1; CE = 1'b0;
        repeat (100) @(negedge CLK);
        BTN = 1'b0;
        repeat (20) @(negedge CLK);
        expect_counts("s7", 0, 0, 0, 0);

        // reset while waiting for a second press
        mark();
        #2 RST = 1'b1;
        #1 chk("s8_rst_short", SHORT_P, 1'b0);
        @(negedge CLK); RST = 1'b0;
        ticks(1'b0, 6); idle(2);
        expect_counts("s8", 0, 0, 0, 0);

        // reset while long-held
        ticks(1'b1, 9);
        mark();
        ticks(1'b1, 1);
        @(negedge CLK); CE = 1'b0;
        chk("s9_held_pre", HELD, 1'b1);
        #2 RST = 1'b1;
        #1 chk("s9_rst_held", HELD, 1'b0);
        @(negedge CLK); BTN = 1'b0; RST = 1'b0;
        ticks(1'b0, 8); idle(2);
        expect_counts("s9", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
